// File: rtl/wb_serial_tx_pkg.sv
// Shared definitions for the Wishbone serial transmitter:
// register offsets, STATUS field positions, FSM encoding and a STATUS packer.
package wb_serial_tx_pkg;

   // Register offsets selected by adr_i[1:0]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RSVD2  = 2'd2;
   localparam logic [1:0] REG_RSVD3  = 2'd3;

   // STATUS word layout: {22'b0, count[7:0], idle, full}
   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_IDLE_BIT  = 1;
   localparam int STAT_COUNT_LSB = 2;
   localparam int STAT_COUNT_W   = 8;

   // Transmitter states
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Assemble the STATUS read word from its fields
   function automatic logic [31:0] pack_status(input logic [7:0] count,
                                               input logic       idle,
                                               input logic       full);
      logic [31:0] word;
      word = '0;
      word[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
      word[STAT_IDLE_BIT]                  = idle;
      word[STAT_FULL_BIT]                  = full;
      return word;
   endfunction

endpackage

// File: rtl/wb_serial_tx_if.sv
// Wishbone-style data bus bundle between the core (master) and the
// serial transmitter (slave).
interface wb_serial_tx_if;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        wen_i;
   logic [3:0]  sel_i;
   logic        stb_i;
   logic        cyc_i;
   logic        ack_o;
   logic        err_o;
   logic        rty_o;

   modport master (
      output adr_i, dat_i, wen_i, sel_i, stb_i, cyc_i,
      input  dat_o, ack_o, err_o, rty_o
   );

   modport slave (
      input  adr_i, dat_i, wen_i, sel_i, stb_i, cyc_i,
      output dat_o, ack_o, err_o, rty_o
   );
endinterface

// File: rtl/wb_serial_tx_fifo.sv
// Circular-buffer FIFO feeding the serial shifter. Head is presented
// combinationally on dout; count is one bit wider than the pointers so
// full and empty are distinguishable.
module tx_fifo #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   localparam int            DEPTH   = 1 << AW;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == CNT_MAX);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at AW bits
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers; reset empties the buffer logically
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/wb_serial_tx.sv
// Memory-mapped 8N1 serial transmitter. A Wishbone-style slave accepts
// DATA writes into a FIFO (stalling the core while full) and serves a
// STATUS word; a bit-timed shifter drains the FIFO onto txd.
module wb_serial_tx
   import wb_serial_tx_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'h0000_0100,
   parameter int          CLKDIV  = 434,
   parameter int          FIFO_AW = 4
) (
   input  logic            clk,
   input  logic            reset,
   wb_serial_tx_if.slave   bus,
   output logic            txd,
   output logic            idle
);

   localparam logic [29:0] BASE_WORD    = BASE[31:2];
   localparam logic [15:0] TIMER_RELOAD = 16'(CLKDIV - 1);

   // FIFO connections
   logic               push, pop;
   logic [7:0]         fifo_dout;
   logic [FIFO_AW:0]   fifo_count;
   logic               fifo_full, fifo_empty;

   // Bus slave state
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [31:0]        dat_o_q, dat_o_d;
   logic               hit, accept, data_wr, mapped;
   logic [1:0]         offset;

   // Shifter state
   tx_state_e          state_q, state_d;
   logic [15:0]        timer_q, timer_d;
   logic [7:0]         shift_q, shift_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic               txd_q, txd_d;
   logic               idle_q, idle_d;
   logic               timer_zero;

   logic               unused_bits;
   assign unused_bits = ^{bus.sel_i, bus.dat_i[31:8]};

   tx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (bus.dat_i[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.ack_o = ack_q;
   assign bus.err_o = err_q;
   assign bus.dat_o = dat_o_q;
   assign bus.rty_o = 1'b0;
   assign txd       = txd_q;
   assign idle      = idle_q;
   assign timer_zero = (timer_q == '0);

   // Bus decode: accept a hit only when no pulse is outstanding and it is
   // not a DATA write into a full FIFO, which waits for space instead
   always_comb begin
      offset  = bus.adr_i[1:0];
      hit     = bus.stb_i & bus.cyc_i & (bus.adr_i[31:2] == BASE_WORD);
      data_wr = bus.wen_i & (offset == REG_DATA);
      mapped  = (offset == REG_DATA) | (offset == REG_STATUS);
      accept  = hit & ~ack_q & ~err_q & ~(data_wr & fifo_full);
      ack_d   = accept & mapped;
      err_d   = accept & ~mapped;
      push    = accept & data_wr;
      dat_o_d = '0;
      if (accept & ~bus.wen_i & (offset == REG_STATUS))
         dat_o_d = pack_status(8'(fifo_count), idle_q, fifo_full);
   end

   // Transmitter next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TX_IDLE:  if (!fifo_empty) state_d = TX_START;
         TX_START: if (timer_zero) state_d = TX_DATA;
         TX_DATA:  if (timer_zero && (bit_idx_q == 3'd7)) state_d = TX_STOP;
         TX_STOP:  if (timer_zero) state_d = TX_IDLE;
         default:  state_d = TX_IDLE;
      endcase
   end

   // Transmitter datapath: bit timer, shift register, line level and pop
   always_comb begin
      timer_d   = timer_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;
      pop       = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               txd_d   = 1'b0;
               timer_d = TIMER_RELOAD;
            end
         end
         TX_START: begin
            if (timer_zero) begin
               txd_d     = shift_q[0];
               timer_d   = TIMER_RELOAD;
               bit_idx_d = 3'd0;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (timer_zero) begin
               timer_d = TIMER_RELOAD;
               shift_d = shift_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  txd_d = 1'b1;
               end else begin
                  txd_d     = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (!timer_zero) timer_d = timer_q - 16'd1;
         end
         default: begin
            txd_d = 1'b1;
         end
      endcase
      idle_d = fifo_empty & (state_q == TX_IDLE);
   end

   // All registers; reset aborts any frame and returns the line high
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_o_q   <= '0;
         state_q   <= TX_IDLE;
         timer_q   <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
         idle_q    <= 1'b1;
      end else begin
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_o_q   <= dat_o_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         idle_q    <= idle_d;
      end
   end

endmodule

// File: tb/tb_wb_serial_tx.sv
// Bench for wb_serial_tx: directed bus steps with random payloads, a
// serial-line decoder and an expected-byte queue as the reference.
module tb_wb_serial_tx;

   localparam logic [31:0] BASE    = 32'h0000_0100;
   localparam int          CLKDIV  = 4;
   localparam int          FIFO_AW = 2;
   localparam int          DEPTH   = 1 << FIFO_AW;

   logic clk;
   logic reset;
   logic txd;
   logic idle;

   int n_checks = 0;
   int n_fail   = 0;
   int frame_errors = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   logic [9:0] mon_frame;
   logic       mon_ok;
   logic       mon_abort;

   wb_serial_tx_if bus_if ();

   wb_serial_tx #(.BASE(BASE), .CLKDIV(CLKDIV), .FIFO_AW(FIFO_AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .txd   (txd),
      .idle  (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line decoder: each frame must be start=0, 8 data LSB first, stop=1,
   // every bit held for exactly CLKDIV cycles
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && txd === 1'b0) begin
            mon_ok    = 1'b1;
            mon_abort = 1'b0;
            for (int b = 0; b < 10; b++) begin
               for (int k = 0; k < CLKDIV; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  if (reset) mon_abort = 1'b1;
                  if (k == 0) mon_frame[b] = txd;
                  else if (txd !== mon_frame[b]) mon_ok = 1'b0;
               end
            end
            if (!mon_abort) begin
               if (mon_frame[0] !== 1'b0 || mon_frame[9] !== 1'b1) mon_ok = 1'b0;
               if (!mon_ok) frame_errors++;
               rx_q.push_back(mon_frame[8:1]);
            end
         end
      end
   end

   function automatic logic [31:0] status_word(input int count, input bit idle_b, input bit full_b);
      return 32'(count * 4 + (idle_b ? 2 : 0) + (full_b ? 1 : 0));
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One bus access: drive now, wait up to max_wait edges for ack/err,
   // release, then spend one idle cycle to look for a repeated pulse
   task automatic apply_stimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdata,
                                 input int max_wait,
                                 output logic got_ack, output logic got_err, output logic [31:0] rdata,
                                 output int waited, output logic extra_pulse,
                                 output logic txd_at_resp, output logic txd_after);
      logic done;
      bus_if.adr_i = adr;
      bus_if.dat_i = wdata;
      bus_if.wen_i = we;
      bus_if.sel_i = 4'hf;
      bus_if.stb_i = 1'b1;
      bus_if.cyc_i = 1'b1;
      got_ack = 1'b0;
      got_err = 1'b0;
      rdata   = '0;
      waited  = 0;
      done    = 1'b0;
      txd_at_resp = 1'bx;
      while (!done && waited <= max_wait) begin
         @(posedge clk);
         #1;
         if (bus_if.ack_o || bus_if.err_o) begin
            got_ack     = bus_if.ack_o;
            got_err     = bus_if.err_o;
            rdata       = bus_if.dat_o;
            txd_at_resp = txd;
            done        = 1'b1;
         end else begin
            waited++;
         end
      end
      bus_if.stb_i = 1'b0;
      bus_if.cyc_i = 1'b0;
      bus_if.wen_i = 1'b0;
      @(posedge clk);
      #1;
      extra_pulse = bus_if.ack_o | bus_if.err_o;
      txd_after   = txd;
   endtask

   task automatic wait_idle(input int budget, output logic ok);
      int n = 0;
      while (!idle && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = idle;
   endtask

   initial begin
      logic        ga, ge, xp, t0, t1, ok;
      logic [31:0] rd;
      int          w, k;
      logic [7:0]  b;

      bus_if.adr_i = '0;
      bus_if.dat_i = '0;
      bus_if.wen_i = 1'b0;
      bus_if.sel_i = 4'h0;
      bus_if.stb_i = 1'b0;
      bus_if.cyc_i = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check_output("reset_txd", txd, 1);
      check_output("reset_idle", idle, 1);
      check_output("reset_ack", bus_if.ack_o, 0);
      check_output("reset_err", bus_if.err_o, 0);
      check_output("reset_dat_o", bus_if.dat_o, 0);
      check_output("rty_tied", bus_if.rty_o, 0);
      reset = 1'b0;

      apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("status_after_reset", rd, status_word(0, 1, 0));
      check_output("status_read_ack", ga, 1);

      // Single byte 0x55: latency, line timing, idle return
      apply_stimulus(BASE, 1'b1, 32'h0000_0055, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("first_ack", ga, 1);
      check_output("first_ack_latency", w, 0);
      check_output("first_single_pulse", xp, 0);
      check_output("txd_high_at_push", t0, 1);
      check_output("txd_start_next_edge", t1, 0);
      k = 1;
      while (!idle && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_output("idle_after_frame_cycles", k, 10 * CLKDIV + 2);
      repeat (3) @(posedge clk);
      #1;
      check_output("rx_count_single", rx_q.size(), 1);
      if (rx_q.size() > 0) check_output("rx_byte_55", rx_q.pop_front(), 8'h55);

      // Reserved offsets, unmapped word, STATUS write
      apply_stimulus(BASE | 32'd2, 1'b1, 32'h0000_00ab, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("off2_err", ge, 1);
      check_output("off2_no_ack", ga, 0);
      check_output("off2_latency", w, 0);
      check_output("off2_single_pulse", xp, 0);
      apply_stimulus(BASE | 32'd3, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("off3_err", ge, 1);
      check_output("off3_no_ack", ga, 0);
      apply_stimulus(BASE + 32'd4, 1'b1, 32'h0000_0011, 6, ga, ge, rd, w, xp, t0, t1);
      check_output("unmapped_no_ack", ga, 0);
      check_output("unmapped_no_err", ge, 0);
      apply_stimulus(BASE | 32'd1, 1'b1, 32'hffff_ffff, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("status_write_ack", ga, 1);
      apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("status_after_errs", rd, status_word(0, 1, 0));
      check_output("txd_quiet_after_errs", txd, 1);
      repeat (2 * CLKDIV) @(posedge clk);
      #1;
      check_output("no_frame_from_errs", rx_q.size(), 0);

      // Burst of DEPTH+2 random bytes: one goes straight to the shifter,
      // DEPTH fill the FIFO, the last waits for space
      for (int i = 0; i < DEPTH + 2; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         apply_stimulus(BASE, 1'b1, {24'($urandom), b}, 200, ga, ge, rd, w, xp, t0, t1);
         check_output("burst_ack", ga, 1);
         check_output("burst_single_pulse", xp, 0);
         if (i < DEPTH + 1) check_output("burst_no_stall", w, 0);
         else check_output("burst_last_stalled", (w > 10) ? 1 : 0, 1);
         if (i == 3) begin
            apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
            check_output("status_count3", rd, status_word(3, 0, 0));
         end
         if (i == DEPTH) begin
            apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
            check_output("status_full", rd, status_word(DEPTH, 0, 1));
         end
      end
      wait_idle(2000, ok);
      check_output("burst_drained", ok, 1);

      // Third byte pushed on the edge where the shifter pops the second
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         apply_stimulus(BASE, 1'b1, {24'h0, b}, 200, ga, ge, rd, w, xp, t0, t1);
         check_output("overlap_ack", ga, 1);
         if (i == 1) begin
            repeat (38) @(posedge clk);
            #1;
         end
      end
      apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("status_count1_overlap", rd, status_word(1, 0, 0));
      wait_idle(2000, ok);
      check_output("overlap_drained", ok, 1);

      // More random bytes so both pointers wrap several times
      for (int i = 0; i < DEPTH + 3; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         apply_stimulus(BASE, 1'b1, {24'h0, b}, 200, ga, ge, rd, w, xp, t0, t1);
         check_output("wrap_ack", ga, 1);
      end
      wait_idle(3000, ok);
      check_output("wrap_drained", ok, 1);
      repeat (3) @(posedge clk);
      #1;

      check_output("rx_count", rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0)
         check_output("rx_byte", rx_q.pop_front(), exp_q.pop_front());
      check_output("frame_errors", frame_errors, 0);

      // Reset in the middle of a frame with bytes still queued
      for (int i = 0; i < 3; i++)
         apply_stimulus(BASE, 1'b1, 32'($urandom), 200, ga, ge, rd, w, xp, t0, t1);
      repeat (15) @(posedge clk);
      #1;
      check_output("midframe_busy", idle, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_output("abort_txd", txd, 1);
      check_output("abort_idle", idle, 1);
      apply_stimulus(BASE | 32'd1, 1'b0, 0, 20, ga, ge, rd, w, xp, t0, t1);
      check_output("abort_status", rd, status_word(0, 1, 0));
      repeat (12 * CLKDIV) @(posedge clk);
      #1;
      check_output("abort_no_frames", rx_q.size(), 0);
      check_output("abort_line_high", txd, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
